// File: rtl/td4x_core.sv
// td4x_core: TD4-compatible CPU with generalised widths, CALL/RET stack, step enable and self-jump halt.
// Latency: one instruction per CLOCK edge when ce=1; rom_addr is the PC combinationally, no pipeline.
// Backpressure: ce=0 or a sticky halt freezes all state; `define TD4X_DEBUG_EN adds the regsel/regdat debug mux.
module td4x_core #(
  parameter int DW          = 8,
  parameter int PW          = 8,
  parameter int IW          = 4,
  parameter int OW          = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          ce,
  output logic [PW-1:0] rom_addr,
  input  logic [DW+3:0] rom_data,
  input  logic [IW-1:0] IN,
  output logic [OW-1:0] OUT,
  output logic          halt,
  output logic          stack_err
`ifdef TD4X_DEBUG_EN
  ,
  input  logic [2:0]    regsel,
  output logic [DW-1:0] regdat
`endif
);

  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SPW;

  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_JNC  = 4'hE;

  logic [PW-1:0]  pc, pc_nxt, pc_inc, tgt;
  logic [DW-1:0]  a, a_nxt, b, b_nxt;
  logic [DW-1:0]  im, src, alu_r;
  logic           c, c_nxt, alu_c;
  logic [OW-1:0]  out_r, out_nxt;
  logic [SPW-1:0] sp, sp_nxt;
  logic           halt_nxt, err_nxt, push, exec;
  logic [3:0]     op;
  // Sized to the full sp range so sp indexes it directly; slots >= STACK_DEPTH are never written.
  logic [PW-1:0]  stk [SLOTS];

  assign op       = rom_data[DW+3:DW];
  assign im       = rom_data[DW-1:0];
  assign tgt      = PW'(im);
  assign pc_inc   = pc + PW'(1);
  assign exec     = ce & ~halt;
  assign rom_addr = pc;
  assign OUT      = out_r;

  always_comb begin
    src = '0;
    case (op)
      4'h0, 4'h4:             src = a;
      4'h1, 4'h5, 4'h8, 4'h9: src = b;
      4'h2, 4'h6:             src = DW'(IN);
      default:                src = '0;
    endcase
  end

  assign {alu_c, alu_r} = {1'b0, src} + {1'b0, im};

  always_comb begin
    pc_nxt   = pc_inc;
    a_nxt    = a;
    b_nxt    = b;
    c_nxt    = alu_c;
    out_nxt  = out_r;
    sp_nxt   = sp;
    halt_nxt = halt;
    err_nxt  = stack_err;
    push     = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: a_nxt = alu_r;
      4'h4, 4'h5, 4'h6, 4'h7: b_nxt = alu_r;
      4'h8, 4'h9, 4'hA, 4'hB: out_nxt = alu_r[OW-1:0];
      OP_RET: begin
        c_nxt = 1'b0;
        if (sp != '0) begin
          pc_nxt = stk[sp - SPW'(1)];
          sp_nxt = sp - SPW'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end
      OP_CALL: begin
        c_nxt  = 1'b0;
        pc_nxt = tgt;
        if (sp < SPW'(STACK_DEPTH)) begin
          push   = 1'b1;
          sp_nxt = sp + SPW'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end
      OP_JNC: begin
        c_nxt = 1'b0;
        if (!c) pc_nxt = tgt;
      end
      default: begin
        // JMP onto itself is the program's way of saying "done".
        c_nxt  = 1'b0;
        pc_nxt = tgt;
        if (tgt == pc) halt_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pc        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= 1'b0;
      out_r     <= '0;
      sp        <= '0;
      halt      <= 1'b0;
      stack_err <= 1'b0;
    end else if (exec) begin
      pc        <= pc_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      c         <= c_nxt;
      out_r     <= out_nxt;
      sp        <= sp_nxt;
      halt      <= halt_nxt;
      stack_err <= err_nxt;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET && exec && push) stk[sp] <= pc_inc;
  end

`ifdef TD4X_DEBUG_EN
  logic [DW-1:0] tos;
  assign tos = (sp == '0) ? '0 : DW'(stk[sp - SPW'(1)]);

  always_comb begin
    regdat = '0;
    case (regsel)
      3'd0:    regdat = DW'(pc);
      3'd1:    regdat = a;
      3'd2:    regdat = b;
      3'd3:    regdat = tos;
      3'd4:    regdat = DW'({halt, stack_err, sp, c});
      3'd5:    regdat = DW'(out_r);
      3'd6:    regdat = DW'(IN);
      default: regdat = '0;
    endcase
  end
`endif

endmodule
